spi_transaction_ctrl: RTL
=========================

Name: spi_transaction_ctrl

Overview:
Sequences SPI transactions for the SPI interface. It watches the control word and, when send=1, fetches TX bytes from the data RAM and hands each one to the sibling byte shifter. It writes each RX byte back to the RAM and updates send/n_rx_end in the control register through its FSM write port. It also drives chip select.

Parameters:
DATA_WIDTH, 32, width of control word and data RAM word
ADDR_WIDTH, 9, data RAM address width; max 512 transfers
CS_DLY, 2, cycles of CS setup before first byte and CS hold after last byte (>=1)

Ports:
clk_i  in  1  system clock (10 MHz)
rst_i  in  1  synchronous reset, active-high
ctrl_i  in  DATA_WIDTH  current control word (palabra_control)
ctrl_wr_o  in→out  1  write enable to the control register's FSM port (wr_2)
send_o  out  1  new send value written on ctrl_wr_o (send_clear)
n_rx_end_o  out  10  completed-transfer count written on ctrl_wr_o
mem_addr_o  out  ADDR_WIDTH  data RAM address
mem_rdata_i  in  DATA_WIDTH  RAM read data, valid 1 cycle after address
mem_we_o  out  1  RAM write enable
mem_wdata_o  out  DATA_WIDTH  RAM write data: {zeros, rx byte}
sh_start_o  out  1  1-cycle pulse that starts the shifter
sh_tx_o  out  8  byte to transmit, held stable from start until done
sh_done_i  in  1  1-cycle pulse from the shifter when the byte is complete
sh_rx_i  in  8  received byte, valid with sh_done_i
cs_n_o  out  1  SPI chip select, active low
busy_o  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Control word fields: bit0 send; bit1 all_1s; bit2 all_0s; [12:4] n_tx_end (9 bits); [25:16] n_rx_end.
- Transfer count is n_tx_end+1, giving 1..512 transfers.
- Reset values: cs_n_o=1. All other outputs are 0, including mem_addr_o and sh_tx_o. Counters are 0 and the state is IDLE.
- Reset mid-operation: the next edge forces IDLE and cs_n_o=1, with no ctrl/mem write. The shifter is reset by the same rst_i.
- IDLE: when ctrl_i.send=1, latch n_tx_end, all_1s and all_0s. Then clear idx to 0, drive cs_n_o=0 and go to CS_SETUP. Later ctrl_i changes are ignored until IDLE.
- CS_SETUP: wait CS_DLY cycles, drive mem_addr_o=idx, then go to FETCH.
- FETCH: wait 1 cycle for RAM read latency, then go to START.
- START: choose the TX byte with precedence all_1s (8'hFF) > all_0s (8'h00) > mem_rdata_i[7:0]. Register it to sh_tx_o, pulse sh_start_o for 1 cycle, then go to SHIFT.
- SHIFT: wait for sh_done_i.
  - Capture sh_rx_i.
  - Assert mem_we_o with mem_addr_o=idx and mem_wdata_o = zero-extended rx byte.
  - Assert ctrl_wr_o with send_o=1 and n_rx_end_o=idx+1.
  - All of these last exactly 1 cycle.
  - Then go to NEXT.
- NEXT: if idx == latched n_tx_end, go to CS_HOLD. Otherwise increment idx, drive mem_addr_o=idx+1 and go to FETCH.
- CS_HOLD: wait CS_DLY cycles with cs_n_o=0, then set cs_n_o=1 and go to DONE.
- DONE: pulse ctrl_wr_o for 1 cycle with send_o=0 and n_rx_end_o=n_tx_end+1, then go to IDLE.
  - IDLE does not re-arm on the stale send bit: the clear write lands on the same edge the FSM enters IDLE.
- Simultaneous client write: the control register gives the client write (wr_1) priority over ctrl_wr_o. The controller does not retry.
  - A client write of send=1 during a transfer has no effect until IDLE.
  - If a client write collides with the DONE write and leaves send=1, a new transaction starts from IDLE.
- sh_done_i outside SHIFT is ignored.
- Widths: idx and n_rx_end are 10 bits; idx+1 never wraps because the maximum is 512.
- Latency per byte: FETCH(1) + START(1) + shifter time + SHIFT exit(1) + NEXT(1).

Decomposition:
- spi_pkg additions: the state enum type (IDLE, CS_SETUP, FETCH, START, SHIFT, NEXT, CS_HOLD, DONE), control-field bit-position localparams, and the ALL1_BYTE and ALL0_BYTE constants. The palabra_control struct already lives in spi_pkg and is reused for ctrl_i.
- No sub-module. The CS delay counter and idx counter are inline; the byte shifter stays a sibling instance.

Test Plan:
- Reset: assert rst_i for 2 cycles mid-SHIFT -> cs_n_o=1, busy_o=0, no mem_we_o or ctrl_wr_o pulses afterwards.
- Single transfer: RAM[0]=0xA5, ctrl=send=1, n_tx_end=0; shifter model returns 0x3C -> sh_tx_o=0xA5 and RAM[0]=0x0000003C. ctrl_wr_o pulses twice: (send=1, n_rx_end=1) then (send=0, n_rx_end=1). cs_n_o is low for at least 2*CS_DLY cycles around the byte.
- Multi transfer: n_tx_end=3, RAM[0..3]=0x11,0x22,0x33,0x44 -> TX order 11,22,33,44, addresses 0..3 written, n_rx_end steps 1,2,3,4 and ends with send=0.
- Overrides: all_1s=1 and all_0s=1 with RAM=0x55 -> sh_tx_o=0xFF; all_0s only -> 0x00.
- Boundary: n_tx_end=511 -> 512 transfers, final n_rx_end_o=512, idx does not wrap, last write to address 511.
- Ignored events: a spurious sh_done_i in IDLE produces no writes; a client write of send=1 mid-transfer does not restart the sequence or alter the count.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI types: the control-word layout, field bit positions, and the
// transaction controller's state encoding.
package spi_pkg;

  // Layout of the 32-bit control word (palabra_control).
  typedef struct packed {
    logic [5:0] rsvd_hi;
    logic [9:0] n_rx_end;
    logic [2:0] rsvd_mid;
    logic [8:0] n_tx_end;
    logic       rsvd_lo;
    logic       all_0s;
    logic       all_1s;
    logic       send;
  } palabra_control_t;

  localparam int CTRL_SEND_BIT = 0;
  localparam int CTRL_ALL1_BIT = 1;
  localparam int CTRL_ALL0_BIT = 2;
  localparam int CTRL_NTX_LSB  = 4;
  localparam int CTRL_NTX_MSB  = 12;
  localparam int CTRL_NRX_LSB  = 16;
  localparam int CTRL_NRX_MSB  = 25;

  localparam logic [7:0] ALL1_BYTE = 8'hFF;
  localparam logic [7:0] ALL0_BYTE = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    FETCH,
    START,
    SHIFT,
    NEXT,
    CS_HOLD,
    DONE
  } spi_state_t;

endpackage

// File: rtl/spi_transaction_ctrl.sv
// Sequences a burst of SPI byte transfers: fetches TX bytes from the data RAM,
// drives the sibling byte shifter, stores RX bytes and reports progress.
module spi_transaction_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int CS_DLY     = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] ctrl_i,
  output logic                  ctrl_wr_o,
  output logic                  send_o,
  output logic [9:0]            n_rx_end_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  output logic                  sh_start_o,
  output logic [7:0]            sh_tx_o,
  input  logic                  sh_done_i,
  input  logic [7:0]            sh_rx_i,
  output logic                  cs_n_o,
  output logic                  busy_o
);

  localparam int DLY_W = (CS_DLY > 1) ? $clog2(CS_DLY) : 1;
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(CS_DLY - 1);

  palabra_control_t ctrl_w;
  assign ctrl_w = palabra_control_t'(ctrl_i[31:0]);

  spi_state_t            state_reg, state_next;
  logic [DLY_W-1:0]      dly_reg, dly_next;
  logic [9:0]            idx_reg, idx_next;
  logic [8:0]            ntx_reg, ntx_next;
  logic                  all1_reg, all1_next;
  logic                  all0_reg, all0_next;
  logic                  cs_n_reg, cs_n_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [7:0]            tx_reg, tx_next;
  logic                  start_reg, start_next;
  logic                  we_reg, we_next;
  logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;
  logic                  cwr_reg, cwr_next;
  logic                  send_reg, send_next;
  logic [9:0]            nrx_reg, nrx_next;

  logic [9:0] idx_inc;
  assign idx_inc = idx_reg + 10'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      dly_reg   <= '0;
      idx_reg   <= '0;
      ntx_reg   <= '0;
      all1_reg  <= 1'b0;
      all0_reg  <= 1'b0;
      cs_n_reg  <= 1'b1;
      addr_reg  <= '0;
      tx_reg    <= '0;
      start_reg <= 1'b0;
      we_reg    <= 1'b0;
      wdata_reg <= '0;
      cwr_reg   <= 1'b0;
      send_reg  <= 1'b0;
      nrx_reg   <= '0;
    end else begin
      state_reg <= state_next;
      dly_reg   <= dly_next;
      idx_reg   <= idx_next;
      ntx_reg   <= ntx_next;
      all1_reg  <= all1_next;
      all0_reg  <= all0_next;
      cs_n_reg  <= cs_n_next;
      addr_reg  <= addr_next;
      tx_reg    <= tx_next;
      start_reg <= start_next;
      we_reg    <= we_next;
      wdata_reg <= wdata_next;
      cwr_reg   <= cwr_next;
      send_reg  <= send_next;
      nrx_reg   <= nrx_next;
    end
  end

  // Pulse outputs are registered on the state exit, so each one is asserted
  // during the following state; the DONE clear write therefore lands on the
  // very edge that returns the FSM to IDLE and the stale send bit is never seen.
  always_comb begin
    state_next = state_reg;
    dly_next   = dly_reg;
    idx_next   = idx_reg;
    ntx_next   = ntx_reg;
    all1_next  = all1_reg;
    all0_next  = all0_reg;
    cs_n_next  = cs_n_reg;
    addr_next  = addr_reg;
    tx_next    = tx_reg;
    start_next = 1'b0;
    we_next    = 1'b0;
    wdata_next = wdata_reg;
    cwr_next   = 1'b0;
    send_next  = send_reg;
    nrx_next   = nrx_reg;
    case (state_reg)
      IDLE: begin
        if (ctrl_w.send) begin
          ntx_next   = ctrl_w.n_tx_end;
          all1_next  = ctrl_w.all_1s;
          all0_next  = ctrl_w.all_0s;
          idx_next   = '0;
          dly_next   = '0;
          cs_n_next  = 1'b0;
          state_next = CS_SETUP;
        end
      end
      CS_SETUP: begin
        if (dly_reg == DLY_LAST) begin
          addr_next  = idx_reg[ADDR_WIDTH-1:0];
          state_next = FETCH;
        end else begin
          dly_next = dly_reg + 1'b1;
        end
      end
      FETCH: state_next = START;
      START: begin
        if (all1_reg)      tx_next = ALL1_BYTE;
        else if (all0_reg) tx_next = ALL0_BYTE;
        else               tx_next = mem_rdata_i[7:0];
        start_next = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (sh_done_i) begin
          we_next    = 1'b1;
          wdata_next = {{(DATA_WIDTH-8){1'b0}}, sh_rx_i};
          cwr_next   = 1'b1;
          send_next  = 1'b1;
          nrx_next   = idx_inc;
          state_next = NEXT;
        end
      end
      NEXT: begin
        if (idx_reg == {1'b0, ntx_reg}) begin
          dly_next   = '0;
          state_next = CS_HOLD;
        end else begin
          idx_next   = idx_inc;
          addr_next  = idx_inc[ADDR_WIDTH-1:0];
          state_next = FETCH;
        end
      end
      CS_HOLD: begin
        if (dly_reg == DLY_LAST) begin
          cs_n_next  = 1'b1;
          cwr_next   = 1'b1;
          send_next  = 1'b0;
          nrx_next   = {1'b0, ntx_reg} + 10'd1;
          state_next = DONE;
        end else begin
          dly_next = dly_reg + 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign ctrl_wr_o   = cwr_reg;
  assign send_o      = send_reg;
  assign n_rx_end_o  = nrx_reg;
  assign mem_addr_o  = addr_reg;
  assign mem_we_o    = we_reg;
  assign mem_wdata_o = wdata_reg;
  assign sh_start_o  = start_reg;
  assign sh_tx_o     = tx_reg;
  assign cs_n_o      = cs_n_reg;
  assign busy_o      = (state_reg != IDLE);

  logic unused_bits;
  assign unused_bits = ^{ctrl_w.rsvd_hi, ctrl_w.n_rx_end, ctrl_w.rsvd_mid,
                         ctrl_w.rsvd_lo, mem_rdata_i[DATA_WIDTH-1:8]};

endmodule
